// File: rtl/phase_scan_ctrl.sv
// PLL phase sweep sequencer: counts detA/detB per phase step, stores them, returns the PLL to the best detA step.
// Readback has one cycle of latency; start is ignored while busy and the FSM stalls on phasedone (bounded by TIMEOUT).
module phase_scan_ctrl #(
    parameter int NSTEPS  = 16,
    parameter int CNT_W   = 16,
    parameter int DWELL_W = 16,
    parameter int SETTLE  = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [DWELL_W-1:0]        dwell_cycles,
    input  logic [2:0]                veto_cfg,
    input  logic                      detA,
    input  logic                      detB,
    input  logic                      phasedone,
    output logic                      phasestep,
    output logic                      phaseupdown,
    output logic [2:0]                vetoLast,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [$clog2(NSTEPS)-1:0] best_step,
    input  logic [$clog2(NSTEPS)-1:0] rd_addr,
    output logic [CNT_W-1:0]          rd_countA,
    output logic [CNT_W-1:0]          rd_countB
);

    localparam int SW    = $clog2(NSTEPS);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int ST_W  = $clog2(SETTLE + 1);
    localparam int TW0   = (DWELL_W > TO_W) ? DWELL_W : TO_W;
    localparam int TMR_W = (TW0 > ST_W) ? TW0 : ST_W;

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_COUNT, S_STORE, S_STEP, S_WAIT_PD, S_RETURN, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [SW-1:0]      step_q, step_d;
    logic [SW-1:0]      best_q, best_d;
    logic [SW-1:0]      best_step_q, best_step_d;
    logic [SW:0]        rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0]   cnt_b_q, cnt_b_d;
    logic [CNT_W-1:0]   bestval_q, bestval_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               err_q, err_d;
    logic               pd_low_q, pd_low_d;
    logic               ret_q, ret_d;
    logic [2:0]         veto_q, veto_d;
    logic [CNT_W-1:0]   rd_a_q, rd_b_q;
    logic [CNT_W-1:0]   mem_a [NSTEPS];
    logic [CNT_W-1:0]   mem_b [NSTEPS];

    logic [DWELL_W-1:0] dwell_eff;
    logic [TMR_W-1:0]   dwell_last;

    assign dwell_eff  = (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;
    assign dwell_last = TMR_W'(dwell_eff) - TMR_W'(1);

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        best_d      = best_q;
        best_step_d = best_step_q;
        rem_d       = rem_q;
        cnt_a_d     = cnt_a_q;
        cnt_b_d     = cnt_b_q;
        bestval_d   = bestval_q;
        tmr_d       = tmr_q;
        err_d       = err_q;
        pd_low_d    = pd_low_q;
        ret_d       = ret_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_SETTLE;
                    step_d    = '0;
                    cnt_a_d   = '0;
                    cnt_b_d   = '0;
                    best_d    = '0;
                    bestval_d = '0;
                    err_d     = 1'b0;
                    tmr_d     = '0;
                    ret_d     = 1'b0;
                end
            end
            S_SETTLE: begin
                if (tmr_q == TMR_W'(SETTLE - 1)) begin
                    state_d = S_COUNT;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_COUNT: begin
                if (detA && (cnt_a_q != '1)) cnt_a_d = cnt_a_q + CNT_W'(1);
                if (detB && (cnt_b_q != '1)) cnt_b_d = cnt_b_q + CNT_W'(1);
                if (tmr_q >= dwell_last) begin
                    state_d = S_STORE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_STORE: begin
                // Strict compare so a tie keeps the earlier step.
                if (cnt_a_q > bestval_q) begin
                    best_d    = step_q;
                    bestval_d = cnt_a_q;
                end
                cnt_a_d = '0;
                cnt_b_d = '0;
                if (step_q == SW'(NSTEPS - 1)) begin
                    state_d = S_RETURN;
                    rem_d   = {1'b0, best_d} + (SW + 1)'(1);
                end else begin
                    state_d  = S_STEP;
                    tmr_d    = '0;
                    pd_low_d = 1'b0;
                end
            end
            S_STEP: begin
                // A fast PLL may already drop phasedone while phasestep is high.
                if (!phasedone) pd_low_d = 1'b1;
                if (tmr_q == TMR_W'(1)) begin
                    state_d = S_WAIT_PD;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_WAIT_PD: begin
                if (pd_low_q && phasedone) begin
                    tmr_d = '0;
                    if (ret_q) begin
                        state_d = S_RETURN;
                    end else begin
                        state_d = S_SETTLE;
                        step_d  = step_q + SW'(1);
                    end
                end else if (tmr_q == TMR_W'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                    if (!phasedone) pd_low_d = 1'b1;
                end
            end
            S_RETURN: begin
                ret_d = 1'b1;
                if (rem_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    rem_d    = rem_q - (SW + 1)'(1);
                    state_d  = S_STEP;
                    tmr_d    = '0;
                    pd_low_d = 1'b0;
                end
            end
            S_DONE: begin
                best_step_d = best_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign veto_d = (state_d != S_IDLE) ? 3'b000 : veto_cfg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            best_q      <= '0;
            best_step_q <= '0;
            rem_q       <= '0;
            cnt_a_q     <= '0;
            cnt_b_q     <= '0;
            bestval_q   <= '0;
            tmr_q       <= '0;
            err_q       <= 1'b0;
            pd_low_q    <= 1'b0;
            ret_q       <= 1'b0;
            veto_q      <= veto_cfg;
            rd_a_q      <= '0;
            rd_b_q      <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            best_q      <= best_d;
            best_step_q <= best_step_d;
            rem_q       <= rem_d;
            cnt_a_q     <= cnt_a_d;
            cnt_b_q     <= cnt_b_d;
            bestval_q   <= bestval_d;
            tmr_q       <= tmr_d;
            err_q       <= err_d;
            pd_low_q    <= pd_low_d;
            ret_q       <= ret_d;
            veto_q      <= veto_d;
            rd_a_q      <= mem_a[rd_addr];
            rd_b_q      <= mem_b[rd_addr];
        end
    end

    // Result array is deliberately unreset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (state_q == S_STORE) begin
            mem_a[step_q] <= cnt_a_q;
            mem_b[step_q] <= cnt_b_q;
        end
    end

    assign phasestep   = (state_q == S_STEP);
    assign phaseupdown = 1'b1;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign err         = err_q;
    assign best_step   = best_step_q;
    assign vetoLast    = veto_q;
    assign rd_countA   = rd_a_q;
    assign rd_countB   = rd_b_q;

endmodule

// File: tb/tb_phase_scan_ctrl.sv
// Directed bench for phase_scan_ctrl with a PLL phasedone model and a step-indexed detector pattern.
module tb_phase_scan_ctrl;

    localparam int NST = 4;
    localparam int CW  = 16;
    localparam int DW  = 17;
    localparam int ST  = 8;
    localparam int TO  = 20;
    localparam int SW  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] dwell = '0;
    logic [2:0]    veto_cfg = 3'b101;
    logic          detA = 1'b0;
    logic          detB = 1'b0;
    logic          phasedone = 1'b1;
    logic          phasestep, phaseupdown, busy, done, err;
    logic [2:0]    vetoLast;
    logic [SW-1:0] best_step;
    logic [SW-1:0] rd_addr = '0;
    logic [CW-1:0] rd_countA, rd_countB;

    int checks = 0;
    int errors = 0;

    int   ps_rises = 0, ps_run = 0, bad_w = 0, dip = 0, done_cnt = 0;
    logic ps_prev = 1'b0;
    int   rise_base = 0, done_base = 0, bw_base = 0;
    bit   pll_dip = 1'b1;
    logic [3:0] a_mask = '0, b_mask = '0;

    phase_scan_ctrl #(
        .NSTEPS(NST), .CNT_W(CW), .DWELL_W(DW), .SETTLE(ST), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .dwell_cycles(dwell),
        .veto_cfg(veto_cfg), .detA(detA), .detB(detB), .phasedone(phasedone),
        .phasestep(phasestep), .phaseupdown(phaseupdown), .vetoLast(vetoLast),
        .busy(busy), .done(done), .err(err), .best_step(best_step),
        .rd_addr(rd_addr), .rd_countA(rd_countA), .rd_countB(rd_countB)
    );

    always #5 clk = ~clk;

    // PLL: 3-cycle phasedone dip after each phasestep request; detectors follow the step index.
    always @(negedge clk) begin
        int idx;
        if (phasestep && !ps_prev) begin
            ps_rises++;
            if (pll_dip) dip = 3;
        end
        if (phasestep) ps_run++;
        else begin
            if (ps_prev && ps_run != 2) bad_w++;
            ps_run = 0;
        end
        ps_prev = phasestep;
        if (dip > 0) begin
            phasedone = 1'b0;
            dip--;
        end else begin
            phasedone = 1'b1;
        end
        idx  = ps_rises - rise_base;
        detA = (idx >= 0 && idx < 4) ? a_mask[idx] : 1'b0;
        detB = (idx >= 0 && idx < 4) ? b_mask[idx] : 1'b0;
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_scan(input logic [DW-1:0] dw, input logic [3:0] am, input logic [3:0] bm);
        dwell     = dw;
        a_mask    = am;
        b_mask    = bm;
        rise_base = ps_rises;
        done_base = done_cnt;
        bw_base   = bad_w;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_rises(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (ps_rises - rise_base >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic rd(input logic [SW-1:0] a, output logic [CW-1:0] ca, output logic [CW-1:0] cb);
        rd_addr = a;
        tick();
        ca = rd_countA;
        cb = rd_countB;
    endtask

    initial begin
        bit            ok;
        int            n;
        logic [CW-1:0] ca, cb;
        logic [CW-1:0] exp_a [4];
        logic [CW-1:0] exp_b [4];

        // Reset state
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_phasestep", 32'(phasestep), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_best", 32'(best_step), 32'd0);
        chk("rst_rdA", 32'(rd_countA), 32'd0);
        chk("rst_rdB", 32'(rd_countB), 32'd0);
        chk("rst_veto", 32'(vetoLast), 32'd5);
        chk("updown", 32'(phaseupdown), 32'd1);
        reset = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_veto", 32'(vetoLast), 32'd5);

        // Single-step peak at step 2, with a start pulse issued mid-scan
        run_scan(17'd10, 4'b0100, 4'b0010);
        chk("s2_busy", 32'(busy), 32'd1);
        chk("s2_veto_busy", 32'(vetoLast), 32'd0);
        wait_rises(1, 200, ok);
        chk("s2_rise1_seen", 32'(ok), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(600, ok);
        chk("s2_done_seen", 32'(ok), 32'd1);
        chk("s2_err", 32'(err), 32'd0);
        tick();
        chk("s2_done_pulse", 32'(done), 32'd0);
        chk("s2_busy_after", 32'(busy), 32'd0);
        chk("s2_best", 32'(best_step), 32'd2);
        chk("s2_veto_after", 32'(vetoLast), 32'd5);
        chk("s2_steps", 32'(ps_rises - rise_base), 32'd6);
        chk("s2_step_width", 32'(bad_w - bw_base), 32'd0);
        chk("s2_done_cnt", 32'(done_cnt - done_base), 32'd1);
        exp_a = '{16'd0, 16'd0, 16'd10, 16'd0};
        exp_b = '{16'd0, 16'd10, 16'd0, 16'd0};
        for (int i = 0; i < 4; i++) begin
            rd(SW'(i), ca, cb);
            chk($sformatf("s2_A%0d", i), 32'(ca), 32'(exp_a[i]));
            chk($sformatf("s2_B%0d", i), 32'(cb), 32'(exp_b[i]));
        end

        // Tie between steps 1 and 3 keeps the lower step
        run_scan(17'd10, 4'b1010, 4'b0000);
        wait_done(600, ok);
        chk("tie_done_seen", 32'(ok), 32'd1);
        tick();
        chk("tie_best", 32'(best_step), 32'd1);
        chk("tie_steps", 32'(ps_rises - rise_base), 32'd5);
        rd(SW'(1), ca, cb);
        chk("tie_A1", 32'(ca), 32'd10);
        rd(SW'(3), ca, cb);
        chk("tie_A3", 32'(ca), 32'd10);

        // Saturation: step 0 dwell exceeds the counter range, later steps short
        run_scan(17'd65540, 4'b1111, 4'b0000);
        wait_rises(1, 66000, ok);
        chk("sat_rise1_seen", 32'(ok), 32'd1);
        dwell = 17'd5;
        wait_done(1000, ok);
        chk("sat_done_seen", 32'(ok), 32'd1);
        tick();
        chk("sat_best", 32'(best_step), 32'd0);
        chk("sat_steps", 32'(ps_rises - rise_base), 32'd4);
        rd(SW'(0), ca, cb);
        chk("sat_A0", 32'(ca), 32'hFFFF);
        chk("sat_B0", 32'(cb), 32'd0);
        rd(SW'(1), ca, cb);
        chk("sat_A1", 32'(ca), 32'd5);

        // phasedone never drops: timeout after TIMEOUT+1 cycles in WAIT_PD
        pll_dip = 1'b0;
        run_scan(17'd3, 4'b0000, 4'b0000);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (phasestep) ok = 1'b1;
            else tick();
        end
        chk("to_step_seen", 32'(ok), 32'd1);
        for (int i = 0; i < 10 && phasestep; i++) tick();
        n = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            n++;
            tick();
        end
        chk("to_wait_cycles", 32'(n), 32'(TO + 1));
        chk("to_done", 32'(done), 32'd1);
        chk("to_err", 32'(err), 32'd1);
        tick();
        chk("to_busy_after", 32'(busy), 32'd0);
        chk("to_err_sticky", 32'(err), 32'd1);
        chk("to_done_cnt", 32'(done_cnt - done_base), 32'd1);

        // Reset during COUNT aborts immediately; start clears err
        pll_dip = 1'b1;
        run_scan(17'd100, 4'b1111, 4'b0000);
        chk("ab_err_clr", 32'(err), 32'd0);
        chk("ab_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 15; i++) tick();
        reset = 1'b1;
        tick();
        chk("ab_busy_rst", 32'(busy), 32'd0);
        chk("ab_phasestep", 32'(phasestep), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        chk("ab_veto", 32'(vetoLast), 32'd5);
        reset = 1'b0;
        tick();
        chk("ab_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
